// File: rtl/freq_div_ctrl.sv
// Fractional clock-enable generator: emits M enable pulses per N input cycles,
// with a shadowed retune that switches ratio only on a pulse boundary.
module freq_div_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK_in,
  input  logic             RST,
  input  logic             EN,
  input  logic             CFG_valid,
  input  logic [WIDTH-1:0] CFG_div_in,
  input  logic [WIDTH-1:0] CFG_div_out,
  output logic             CFG_ready,
  output logic             CFG_err,
  output logic             CLK_en,
  output logic [WIDTH-1:0] CUR_div_in,
  output logic [WIDTH-1:0] CUR_div_out,
  output logic             STAT_pend
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shd_in;
  logic [WIDTH-1:0] shd_out;

  logic [WIDTH:0]   sum;
  logic             hit;
  logic             xfer;
  logic             legal;
  logic [WIDTH-1:0] acc_nxt;

  // One extra bit on the sum so acc + M never wraps before the compare.
  assign sum     = {1'b0, acc} + {1'b0, CUR_div_out};
  assign hit     = (sum >= {1'b0, CUR_div_in});
  assign acc_nxt = hit ? WIDTH'(sum - {1'b0, CUR_div_in}) : WIDTH'(sum);

  assign CFG_ready = (state != PEND);
  assign xfer      = CFG_valid && CFG_ready;
  assign legal     = (CFG_div_out != '0) && (CFG_div_in != '0) &&
                     (CFG_div_in >= CFG_div_out);

  always_ff @(posedge CLK_in) begin
    if (RST) begin
      state       <= IDLE;
      acc         <= '0;
      shd_in      <= '0;
      shd_out     <= '0;
      CUR_div_in  <= '0;
      CUR_div_out <= '0;
      CLK_en      <= 1'b0;
      CFG_err     <= 1'b0;
      STAT_pend   <= 1'b0;
    end else begin
      CFG_err <= xfer && !legal;
      case (state)
        IDLE: begin
          CLK_en <= 1'b0;
          if (xfer && legal) begin
            CUR_div_in  <= CFG_div_in;
            CUR_div_out <= CFG_div_out;
            acc         <= '0;
            state       <= RUN;
          end
        end

        RUN: begin
          if (EN) begin
            CLK_en <= hit;
            acc    <= acc_nxt;
          end else begin
            CLK_en <= 1'b0;
          end
          // Accepted retune waits in the shadow until the next pulse.
          if (xfer && legal) begin
            shd_in    <= CFG_div_in;
            shd_out   <= CFG_div_out;
            STAT_pend <= 1'b1;
            state     <= PEND;
          end
        end

        PEND: begin
          if (EN) begin
            CLK_en <= hit;
            if (hit) begin
              CUR_div_in  <= shd_in;
              CUR_div_out <= shd_out;
              acc         <= '0;
              STAT_pend   <= 1'b0;
              state       <= RUN;
            end else begin
              acc <= acc_nxt;
            end
          end else begin
            CLK_en <= 1'b0;
          end
        end

        default: begin
          CLK_en <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl: vector table plus directed multi-cycle sequences,
// expectations queued at drive time and checked after the clock edge.
module tb_freq_div_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NVEC  = 32;

  typedef struct {
    logic             rst;
    logic             en;
    logic             vld;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] m;
    logic             ce;
    logic             err;
    logic             pend;
    logic             rdy;
    logic [WIDTH-1:0] cn;
    logic [WIDTH-1:0] cm;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [WIDTH-1:0] cfg_div_in = '0;
  logic [WIDTH-1:0] cfg_div_out = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_en;
  logic [WIDTH-1:0] cur_div_in;
  logic [WIDTH-1:0] cur_div_out;
  logic             stat_pend;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t exp_q[$];
  vec_t tbl[NVEC];

  freq_div_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK_in     (clk),
    .RST        (rst),
    .EN         (en),
    .CFG_valid  (cfg_valid),
    .CFG_div_in (cfg_div_in),
    .CFG_div_out(cfg_div_out),
    .CFG_ready  (cfg_ready),
    .CFG_err    (cfg_err),
    .CLK_en     (clk_en),
    .CUR_div_in (cur_div_in),
    .CUR_div_out(cur_div_out),
    .STAT_pend  (stat_pend)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic r, input logic e, input logic v,
                              input int n, input int m,
                              input logic ce, input logic er, input logic pd,
                              input logic rd, input int cn, input int cm);
    vec_t x;
    x.rst = r; x.en = e; x.vld = v;
    x.n = WIDTH'(n); x.m = WIDTH'(m);
    x.ce = ce; x.err = er; x.pend = pd; x.rdy = rd;
    x.cn = WIDTH'(cn); x.cm = WIDTH'(cm);
    return x;
  endfunction

  task automatic check(input string tag, input string fld,
                       input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s %s: got %0d expected %0d", tag, fld, got, want);
    end
  endtask

  // Drive one edge's inputs, queue expectations, compare just after the edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    rst         = v.rst;
    en          = v.en;
    cfg_valid   = v.vld;
    cfg_div_in  = v.n;
    cfg_div_out = v.m;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, "clk_en",      WIDTH'(clk_en),    WIDTH'(e.ce));
    check(tag, "cfg_err",     WIDTH'(cfg_err),   WIDTH'(e.err));
    check(tag, "stat_pend",   WIDTH'(stat_pend), WIDTH'(e.pend));
    check(tag, "cfg_ready",   WIDTH'(cfg_ready), WIDTH'(e.rdy));
    check(tag, "cur_div_in",  cur_div_in,        e.cn);
    check(tag, "cur_div_out", cur_div_out,       e.cm);
  endtask

  task automatic do_reset(input string tag);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), tag);
  endtask

  initial begin
    int pulses;
    int last;
    int max_gap;

    //              rst en vld  N    M   ce err pd rdy  cN   cM
    tbl[0]  = mk(1, 0, 0,   0,   0,  0, 0,  0, 1,   0,   0);
    tbl[1]  = mk(0, 1, 0,   0,   0,  0, 0,  0, 1,   0,   0);
    tbl[2]  = mk(0, 1, 1,   2,   3,  0, 1,  0, 1,   0,   0);
    tbl[3]  = mk(0, 1, 1,   4,   1,  0, 0,  0, 1,   4,   1);
    tbl[4]  = mk(0, 1, 0,   0,   0,  0, 0,  0, 1,   4,   1);
    tbl[5]  = mk(0, 1, 0,   0,   0,  0, 0,  0, 1,   4,   1);
    tbl[6]  = mk(0, 1, 0,   0,   0,  0, 0,  0, 1,   4,   1);
    tbl[7]  = mk(0, 1, 0,   0,   0,  1, 0,  0, 1,   4,   1);
    tbl[8]  = mk(0, 1, 0,   0,   0,  0, 0,  0, 1,   4,   1);
    tbl[9]  = mk(0, 1, 1,   5,   0,  0, 1,  0, 1,   4,   1);
    tbl[10] = mk(0, 1, 1,   0,   0,  0, 1,  0, 1,   4,   1);
    tbl[11] = mk(0, 1, 0,   0,   0,  1, 0,  0, 1,   4,   1);
    tbl[12] = mk(0, 1, 1,   3,   5,  0, 1,  0, 1,   4,   1);
    tbl[13] = mk(0, 0, 0,   0,   0,  0, 0,  0, 1,   4,   1);
    tbl[14] = mk(0, 1, 0,   0,   0,  0, 0,  0, 1,   4,   1);
    tbl[15] = mk(0, 1, 0,   0,   0,  0, 0,  0, 1,   4,   1);
    tbl[16] = mk(0, 1, 0,   0,   0,  1, 0,  0, 1,   4,   1);
    tbl[17] = mk(0, 1, 1,   2,   2,  0, 0,  1, 0,   4,   1);
    tbl[18] = mk(0, 1, 1,   9,   1,  0, 0,  1, 0,   4,   1);
    tbl[19] = mk(0, 1, 0,   0,   0,  0, 0,  1, 0,   4,   1);
    tbl[20] = mk(0, 1, 0,   0,   0,  1, 0,  0, 1,   2,   2);
    tbl[21] = mk(0, 1, 0,   0,   0,  1, 0,  0, 1,   2,   2);
    tbl[22] = mk(0, 1, 0,   0,   0,  1, 0,  0, 1,   2,   2);
    tbl[23] = mk(0, 0, 0,   0,   0,  0, 0,  0, 1,   2,   2);
    tbl[24] = mk(1, 1, 1,   5,   1,  0, 0,  0, 1,   0,   0);
    tbl[25] = mk(0, 0, 1, 255, 255,  0, 0,  0, 1, 255, 255);
    tbl[26] = mk(0, 1, 0,   0,   0,  1, 0,  0, 1, 255, 255);
    tbl[27] = mk(0, 1, 1, 255, 254,  1, 0,  1, 0, 255, 255);
    tbl[28] = mk(0, 1, 0,   0,   0,  1, 0,  0, 1, 255, 254);
    tbl[29] = mk(0, 1, 0,   0,   0,  0, 0,  0, 1, 255, 254);
    tbl[30] = mk(0, 1, 0,   0,   0,  1, 0,  0, 1, 255, 254);
    tbl[31] = mk(0, 1, 0,   0,   0,  1, 0,  0, 1, 255, 254);

    for (int i = 0; i < int'(NVEC); i++)
      step(tbl[i], $sformatf("tbl[%0d]", i));

    // Integer division: pulse on enabled edges 4, 8, 12.
    do_reset("int_rst");
    step(mk(0, 0, 1, 4, 1, 0, 0, 0, 1, 4, 1), "int_cfg");
    for (int k = 1; k <= 12; k++)
      step(mk(0, 1, 0, 0, 0, logic'(k % 4 == 0), 0, 0, 1, 4, 1),
           $sformatf("int[%0d]", k));

    // Fractional 2/3: pattern 0,1,1 and 20 pulses in 30 cycles.
    do_reset("frac_rst");
    step(mk(0, 0, 1, 3, 2, 0, 0, 0, 1, 3, 2), "frac_cfg");
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      step(mk(0, 1, 0, 0, 0, logic'(k % 3 != 1), 0, 0, 1, 3, 2),
           $sformatf("frac[%0d]", k));
      if (clk_en) pulses++;
    end
    check("frac_count", "pulses", WIDTH'(pulses), WIDTH'(20));

    // Retune mid-period: old ratio finishes its period, then every 2nd cycle.
    do_reset("rt_rst");
    step(mk(0, 0, 1, 4, 1, 0, 0, 0, 1, 4, 1), "rt_cfg");
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 1), "rt_e1");
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 1), "rt_e2");
    step(mk(0, 1, 1, 2, 1, 0, 0, 1, 0, 4, 1), "rt_req");
    step(mk(0, 1, 1, 7, 1, 1, 0, 0, 1, 2, 1), "rt_switch");
    last = 0;
    max_gap = 0;
    for (int k = 1; k <= 8; k++) begin
      step(mk(0, 1, 0, 0, 0, logic'(k % 2 == 0), 0, 0, 1, 2, 1),
           $sformatf("rt[%0d]", k));
      if (clk_en) begin
        if (k - last > max_gap) max_gap = k - last;
        last = k;
      end
    end
    check("rt_gap", "max_gap", WIDTH'(max_gap), WIDTH'(2));

    // Hold with EN low at acc=2, then pulse on the 2nd enabled edge.
    do_reset("hold_rst");
    step(mk(0, 0, 1, 4, 1, 0, 0, 0, 1, 4, 1), "hold_cfg");
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 1), "hold_e1");
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 1), "hold_e2");
    for (int k = 1; k <= 5; k++)
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1), $sformatf("hold_off[%0d]", k));
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 1), "hold_on1");
    step(mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 4, 1), "hold_on2");
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 1), "hold_on3");

    // Reset while PEND, then immediate acceptance of a new ratio.
    do_reset("rp_rst0");
    step(mk(0, 0, 1, 4, 1, 0, 0, 0, 1, 4, 1), "rp_cfg");
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 1), "rp_e1");
    step(mk(0, 1, 1, 2, 1, 0, 0, 1, 0, 4, 1), "rp_pend");
    step(mk(1, 1, 1, 5, 1, 0, 0, 0, 1, 0, 0), "rp_reset");
    step(mk(0, 1, 1, 3, 1, 0, 0, 0, 1, 3, 1), "rp_cfg2");
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 1), "rp_e1b");
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 1), "rp_e2b");
    step(mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 3, 1), "rp_e3b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_div_ctrl.md
FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the width of the ratio fields.
REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- CLK_in, input, 1: the single clock; all logic rises on it.
- RST, input, 1: synchronous, active-high reset.
- EN, input, 1: run enable.
- CFG_valid, input, 1: configuration request valid.
- CFG_div_in, input, WIDTH: requested input-cycle count per period (N).
- CFG_div_out, input, WIDTH: requested output pulses per period (M).
- CFG_ready, output, 1: request can be accepted this cycle.
- CFG_err, output, 1: one-cycle pulse when a request is rejected.
- CLK_en, output, 1: divided clock-enable pulse.
- CUR_div_in, output, WIDTH: active N.
- CUR_div_out, output, WIDTH: active M.
- STAT_pend, output, 1: an accepted configuration is waiting to be applied.

Function
REQ-003 A request SHALL transfer on any edge where CFG_valid and CFG_ready are both 1.
REQ-004 A transferred request SHALL be illegal if M == 0, N == 0 or N < M.
- Illegal request: CFG_err = 1 on the next cycle; state, active ratio and accumulator unchanged.
REQ-005 The state machine SHALL have three states: IDLE, RUN, PEND.
- CFG_ready = 1 in IDLE and RUN; 0 in PEND.
REQ-006 IDLE, legal request:
- Next edge loads CUR_div_in/CUR_div_out, clears acc, enters RUN.
- CLK_en stays 0 during IDLE.
REQ-007 RUN with EN = 1, each edge:
- sum = acc + CUR_div_out, computed at WIDTH+1 bits so it cannot overflow.
- If sum >= CUR_div_in: CLK_en <= 1 and acc <= sum - CUR_div_in.
- Otherwise: CLK_en <= 0 and acc <= sum.
REQ-008 Over any CUR_div_in consecutive enabled cycles, CLK_en SHALL be 1 exactly CUR_div_out times.
- M = 1 gives integer division by N.
- M == N gives CLK_en = 1 every enabled cycle.
REQ-009 EN = 0 in RUN or PEND: CLK_en <= 0; acc and state hold; handshake unaffected.
REQ-010 RUN, legal request:
- Store the request in shadow registers, set STAT_pend = 1, enter PEND.
- The active ratio keeps running unchanged.
REQ-011 PEND, period boundary (enabled edge where sum >= CUR_div_in on the old ratio):
- CLK_en <= 1; load the shadow values into CUR_*.
- acc <= 0; STAT_pend <= 0; enter RUN.
- No CLK_en pulse is lost, duplicated or shortened at the switch.
REQ-012 PEND, any other enabled edge: behave as RUN (REQ-007).
REQ-013 CFG_valid in PEND SHALL be ignored (CFG_ready = 0); CFG_err SHALL NOT assert.
REQ-014 Illegal request in RUN SHALL leave the block in RUN with no phase disturbance.
REQ-015 CLK_en, CFG_err and STAT_pend SHALL be registered outputs; CFG_ready SHALL be decoded from the state register.

Reset
REQ-016 RST = 1 at an edge SHALL force, regardless of state or in-flight request:
- state = IDLE; acc = 0; shadow registers = 0.
- CUR_div_in = 0, CUR_div_out = 0.
- CLK_en = 0, CFG_err = 0, STAT_pend = 0.
REQ-017 RST SHALL take priority over CFG_valid and EN on the same edge.
REQ-018 CFG_ready SHALL be 1 in the first cycle after RST deasserts.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Integer: cfg N=4, M=1, EN=1 -> CLK_en high on enabled edges 4, 8, 12 after entering RUN.
- Fractional: cfg N=3, M=2 -> CLK_en pattern 0,1,1 repeating; exactly 20 pulses in 30 cycles.
- Illegal: cfg N=2, M=3 and cfg N=5, M=0 -> CFG_err single pulse each; CUR_* and CLK_en sequence unchanged.
- Retune: running N=4, M=1; cfg N=2, M=1 mid-period -> STAT_pend=1 and CFG_ready=0 until the next old-ratio pulse; then pulses every 2nd cycle with no gap beyond 2.
- Hold: EN low 5 cycles at acc=2 (N=4, M=1) -> no pulses; after EN returns, pulse on the 2nd enabled edge.
- Reset in PEND: RST=1 -> IDLE, all outputs 0, CUR_*=0; subsequent cfg N=3, M=1 accepted immediately.
